// File: rtl/and_reduce_scheduler_if.sv
// Operand-stream and result-stream bundle for the AND-reduction scheduler.
// The master side is the requester/consumer environment; the slave side is the scheduler.
interface and_reduce_scheduler_if #(
    parameter int WIDTH   = 8,
    parameter int REQ_NUM = 4,
    parameter int ID_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
);
    logic [REQ_NUM-1:0]       in_valid;
    logic [REQ_NUM*WIDTH-1:0] in_data;
    logic [REQ_NUM-1:0]       in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_ready;
    logic                     busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_id, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/and_reduce_scheduler.sv
// Round-robin scheduler sharing one AND-reduction accumulator between requesters.
// A granted requester streams BEATS operands; the reduced word is returned tagged with its index.
module and_reduce_scheduler #(
    parameter int WIDTH   = 8,
    parameter int REQ_NUM = 4,
    parameter int BEATS   = 8
) (
    input logic clk,
    input logic rst_n,
    and_reduce_scheduler_if.slave bus
);
    localparam int ID_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CNT_W = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t           state, state_n;
    logic [ID_W-1:0]  gnt, gnt_n, ptr, ptr_n, pick, idx;
    logic             pick_found;
    logic [WIDTH-1:0] acc, acc_n, operand;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             beat;
    logic             out_valid_q, out_valid_n;
    logic [WIDTH-1:0] out_data_q, out_data_n;
    logic [ID_W-1:0]  out_id_q, out_id_n;
    logic             busy_q, busy_n;
    logic [WIDTH-1:0] lane [REQ_NUM];

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_lane
        assign lane[g] = bus.in_data[g*WIDTH +: WIDTH];
    end

    assign operand       = lane[gnt];
    assign beat          = (state == COLLECT) && bus.in_valid[gnt];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.busy      = busy_q;

    // First requesting index at or above ptr, wrapping; the last served index sits lowest.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = ID_W'((int'(ptr) + k) % REQ_NUM);
            if (!pick_found && bus.in_valid[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if (state == COLLECT) begin
            bus.in_ready[gnt] = 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        ptr_n       = ptr;
        acc_n       = acc;
        cnt_n       = cnt;
        out_valid_n = out_valid_q;
        out_data_n  = out_data_q;
        out_id_n    = out_id_q;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_n   = pick;
                    acc_n   = '1;
                    cnt_n   = '0;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (beat) begin
                    acc_n = acc & operand;
                    cnt_n = cnt + CNT_W'(1);
                    // Result registers load on the final beat so they are valid the first DONE cycle.
                    if (cnt == CNT_W'(BEATS - 1)) begin
                        state_n     = DONE;
                        out_valid_n = 1'b1;
                        out_data_n  = acc & operand;
                        out_id_n    = gnt;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n     = IDLE;
                    out_valid_n = 1'b0;
                    ptr_n       = ID_W'((int'(gnt) + 1) % REQ_NUM);
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            ptr         <= '0;
            acc         <= '1;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            gnt         <= gnt_n;
            ptr         <= ptr_n;
            acc         <= acc_n;
            cnt         <= cnt_n;
            out_valid_q <= out_valid_n;
            out_data_q  <= out_data_n;
            out_id_q    <= out_id_n;
            busy_q      <= busy_n;
        end
    end
endmodule

// File: tb/tb_and_reduce_scheduler.sv
// Directed bench for and_reduce_scheduler: requesters push jobs, expected results queue in a
// scoreboard, and a negedge monitor pops and compares each delivered result.
module tb_and_reduce_scheduler;
    localparam int WIDTH    = 8;
    localparam int REQ_NUM  = 4;
    localparam int BEATS    = 8;
    localparam int NO_STALL = BEATS;
    localparam int GUARD    = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    logic       req_valid [REQ_NUM];
    logic [7:0] req_data  [REQ_NUM];
    logic [9:0] sb [$];
    int         rise_times [$];
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    int         raise_cyc;
    logic       job_done;
    logic [BEATS*8-1:0] rr_ops [5];

    and_reduce_scheduler_if #(.WIDTH(WIDTH), .REQ_NUM(REQ_NUM)) bus ();

    and_reduce_scheduler #(.WIDTH(WIDTH), .REQ_NUM(REQ_NUM), .BEATS(BEATS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            bus.in_valid[i]               = req_valid[i];
            bus.in_data[i*WIDTH +: WIDTH] = req_data[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] andAll(input logic [BEATS*8-1:0] ops);
        logic [7:0] r;
        r = 8'hFF;
        for (int b = 0; b < BEATS; b++) r = r & 8'(ops >> (8 * b));
        return r;
    endfunction

    // Presents one job on requester req; stall_after inserts stall_len idle cycles before that beat.
    task automatic applyStimulus(input logic [1:0] req, input logic [BEATS*8-1:0] ops,
                                 input int stall_after, input int stall_len);
        int guard;
        for (int b = 0; b < BEATS; b++) begin
            if (b == stall_after) begin
                req_valid[req] = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            req_valid[req] = 1'b1;
            req_data[req]  = 8'(ops >> (8 * b));
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!bus.in_ready[req] && guard < GUARD);
            checkOutput("in_ready_grant", 32'(bus.in_ready[req]), 32'd1);
            if (!bus.in_ready[req]) begin
                req_valid[req] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        req_valid[req] = 1'b0;
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < GUARD) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Result monitor: compares every cycle out_valid is high, so held results must stay stable.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("valid_after_handshake", 32'(bus.out_valid & prev_hs), 32'd0);
            if (bus.out_valid) begin
                if (!prev_valid) rise_times.push_back(cyc);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    checkOutput("out_data", 32'(bus.out_data), 32'(sb[0][7:0]));
                    checkOutput("out_id", 32'(bus.out_id), 32'(sb[0][9:8]));
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
            prev_valid = bus.out_valid;
            prev_hs    = bus.out_valid & bus.out_ready;
        end else begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end
    end

    initial begin
        for (int i = 0; i < REQ_NUM; i++) begin
            req_valid[i] = 1'b0;
            req_data[i]  = 8'h00;
        end
        bus.out_ready = 1'b1;
        job_done      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("reset_out_id", 32'(bus.out_id), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single job from requester 2; latency counts the raise cycle and the out_valid cycle.
        rise_times.delete();
        sb.push_back({2'd2, 8'h80});
        raise_cyc = cyc;
        applyStimulus(2'd2, 64'hBFDF_EFF7_FBFD_FEFF, NO_STALL, 0);
        waitDrain();
        checkOutput("latency_rises", 32'(rise_times.size()), 32'd1);
        if (rise_times.size() == 1)
            checkOutput("latency", 32'(rise_times[0] - raise_cyc + 1), 32'(BEATS + 2));

        // Round robin from a fresh pointer with every requester continuously requesting.
        doReset();
        rise_times.delete();
        for (int j = 0; j < 5; j++)
            rr_ops[j] = {BEATS{8'hFF}} ^ (64'h1 << (j * 9)) ^ (64'h1 << (j * 13 + 3));
        sb.push_back({2'd0, andAll(rr_ops[0])});
        sb.push_back({2'd1, andAll(rr_ops[1])});
        sb.push_back({2'd2, andAll(rr_ops[2])});
        sb.push_back({2'd3, andAll(rr_ops[3])});
        sb.push_back({2'd0, andAll(rr_ops[4])});
        fork
            begin
                applyStimulus(2'd0, rr_ops[0], NO_STALL, 0);
                applyStimulus(2'd0, rr_ops[4], NO_STALL, 0);
            end
            applyStimulus(2'd1, rr_ops[1], NO_STALL, 0);
            applyStimulus(2'd2, rr_ops[2], NO_STALL, 0);
            applyStimulus(2'd3, rr_ops[3], NO_STALL, 0);
        join
        waitDrain();
        checkOutput("rr_result_count", 32'(rise_times.size()), 32'd5);
        // Period is counted inclusively, the same way as the single-job latency.
        for (int i = 1; i < rise_times.size(); i++)
            checkOutput("rr_period", 32'(rise_times[i] - rise_times[i-1] + 1), 32'(BEATS + 3));

        // Stall on requester 1 plus result backpressure, with rivals requesting mid-job.
        bus.out_ready = 1'b0;
        job_done      = 1'b0;
        sb.push_back({2'd1, andAll(64'hF3FF_7FFF_FEFF_FF5F)});
        fork
            begin
                applyStimulus(2'd1, 64'hF3FF_7FFF_FEFF_FF5F, 4, 3);
                job_done = 1'b1;
            end
            begin
                int guard;
                guard = 0;
                while (!job_done && guard < GUARD) begin
                    @(negedge clk);
                    guard++;
                    checkOutput("others_in_ready", 32'(bus.in_ready & 4'b1101), 32'd0);
                    if (bus.in_ready[1]) begin
                        req_valid[0] = 1'b1;
                        req_valid[3] = 1'b1;
                        req_data[0]  = 8'h00;
                        req_data[3]  = 8'h00;
                    end
                end
            end
        join
        req_valid[0] = 1'b0;
        req_valid[3] = 1'b0;
        checkOutput("busy_in_done", 32'(bus.busy), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("held_result_pending", 32'(sb.size()), 32'd1);
        bus.out_ready = 1'b1;
        waitDrain();
        checkOutput("busy_idle", 32'(bus.busy), 32'd0);

        // All-ones operands, then a zero operand on the seventh beat.
        sb.push_back({2'd0, 8'hFF});
        applyStimulus(2'd0, {BEATS{8'hFF}}, NO_STALL, 0);
        waitDrain();
        sb.push_back({2'd1, 8'h00});
        applyStimulus(2'd1, 64'hFF00_FFFF_FFFF_FFFF, NO_STALL, 0);
        waitDrain();

        // Reset mid-COLLECT after three beats of a requester 3 job.
        begin
            int guard;
            req_valid[3] = 1'b1;
            req_data[3]  = 8'hAA;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!bus.in_ready[3] && guard < GUARD);
            checkOutput("abort_grant", 32'(bus.in_ready[3]), 32'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("abort_out_id", 32'(bus.out_id), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        req_valid[3] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back({2'd0, andAll(rr_ops[2])});
        sb.push_back({2'd3, andAll(rr_ops[3])});
        fork
            applyStimulus(2'd0, rr_ops[2], NO_STALL, 0);
            applyStimulus(2'd3, rr_ops[3], NO_STALL, 0);
        join
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/and_reduce_scheduler.md
# and_reduce_scheduler

Round-robin scheduler that shares one WIDTH-bit multi-operand AND-reduction datapath between REQ_NUM requesters. Each requester submits a job of exactly BEATS operands over a valid/ready stream. The block grants one requester at a time, accumulates the bitwise AND of that requester's operands, and returns the reduced word tagged with the requester index. It sits between the requester-side operand streams and the single result consumer.

## Interface
- WIDTH, 8, operand and result width in bits
- REQ_NUM, 4, number of requesters (≥2)
- BEATS, 8, operands per job (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  REQ_NUM  bit i: requester i presents an operand
- in_data  in  REQ_NUM*WIDTH  requester i operand at bits [i*WIDTH +: WIDTH]
- in_ready  out  REQ_NUM  bit i: operand of requester i consumed this cycle when in_valid[i] is also high
- out_valid  out  1  result available
- out_data  out  WIDTH  AND of all BEATS operands of the job
- out_id  out  max(1,$clog2(REQ_NUM))  index of the requester that owned the job
- out_ready  in  1  consumer accepts the result
- busy  out  1  high in any state other than IDLE

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Internal registers:
  - state: IDLE, COLLECT or DONE
  - gnt: the granted index
  - ptr: the round-robin priority pointer
  - acc: WIDTH bits
  - cnt: $clog2(BEATS+1) bits
- IDLE:
  - in_ready is all 0.
  - If any in_valid bit is high, grant the first set bit found scanning from ptr upward, wrapping modulo REQ_NUM. On that edge: gnt updates, acc is set to all ones, cnt is set to 0, and state moves to COLLECT.
  - If no in_valid bit is high, stay in IDLE.
- COLLECT:
  - in_ready[gnt] is 1. Every other in_ready bit is 0.
  - A beat occurs on a cycle with in_valid[gnt] && in_ready[gnt]. On each beat: acc <= acc & operand, and cnt increments.
  - On the beat where cnt == BEATS-1: go to DONE with acc holding the final AND.
  - A cycle with in_valid[gnt] low is a stall. acc and cnt hold. There is no timeout and no abandonment.
  - A new in_valid from any other requester has no effect until the block returns to IDLE.
- DONE:
  - out_valid = 1, out_data = acc, out_id = gnt. These hold stable until out_ready.
  - On out_valid && out_ready: state goes to IDLE and ptr <= (gnt+1) mod REQ_NUM.
- Reset values: state = IDLE, ptr = 0, gnt = 0, acc = all ones, cnt = 0. All outputs are 0: out_valid, out_data, out_id, in_ready, busy.
- Reset asserted mid-job: the partial job is discarded immediately. After reset release, arbitration restarts with requester 0 as highest priority.
- Outputs driven from registered state only:
  - out_valid, out_data, out_id and busy are registered.
  - in_ready is decoded combinationally from state and gnt, never from in_valid.

## Timing
- Arbitration costs one cycle in IDLE; no operand is consumed in that cycle.
- With no stalls, the first operand beat occurs on the cycle after the grant. out_valid rises on the cycle after the last beat.
- Latency from in_valid first seen high in IDLE to out_valid high: BEATS+2 cycles.
- out_ready may be high before out_valid. The handshake still completes in the first DONE cycle, so out_valid is high for exactly 1 cycle.
- There is one mandatory IDLE cycle between a result handshake and the next grant. Back-to-back job period with no stalls: BEATS+3 cycles.
- in_data is sampled only on beat cycles. Its value while in_ready is low is don't-care.
- Simultaneous requests are resolved purely by ptr. The requester just served becomes lowest priority.

## Test plan
- Single job, BEATS=8, requester 2:
  - Stimulus: operands 0xFF,0xFE,0xFD,0xFB,0xF7,0xEF,0xDF,0xBF with out_ready=1.
  - Required: out_data=0x80 and out_id=2, with out_valid high exactly 10 cycles after in_valid[2] rose.
- Round robin: all 4 requesters hold in_valid high continuously.
  - Required: grant order 0,1,2,3,0.
  - Required: each result carries the matching out_id, and the period is 11 cycles.
- Stall and backpressure:
  - Stimulus: requester 1 drops in_valid for 3 cycles after beat 4, and out_ready is held low for 5 cycles in DONE.
  - Required: the result is correct, and out_data/out_id are stable through the wait.
  - Required: in_ready stays 0 for requesters 0, 2 and 3 throughout.
- All-ones and zero operands:
  - Stimulus: job of eight 0xFF operands. Required: 0xFF.
  - Stimulus: job with one operand 0x00 at beat 7. Required: 0x00.
- Reset mid-COLLECT:
  - Stimulus: pull rst_n low after beat 3 of a requester 3 job.
  - Required: all outputs are 0 immediately.
  - Required: a subsequent fresh job from requesters 3 and 0 together grants 0 first.
